// File: rtl/gray_seq_decoder_pkg.sv
// Shared definitions for the Gray-code link: state encoding and Gray/binary conversion helpers.
// The helpers work on a 32-bit container so any narrower code can be zero-extended into them.
package gray_seq_decoder_pkg;

  localparam int GW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Zero-extension is harmless: the extra high Gray bits are 0 and contribute nothing to the prefix XOR
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_decoder_if.sv
// Sample stream into the decoder and its decoded/status outputs.
interface gray_seq_decoder_if #(
  parameter int W  = 3,
  parameter int CW = 4
);
  logic          in_valid;
  logic [W-1:0]  gray_in;
  logic          out_valid;
  logic [W-1:0]  bin_out;
  logic          locked;
  logic          step_err;
  logic [CW-1:0] wrap_count;
  logic          wrap_ovf;

  modport master (
    output in_valid, gray_in,
    input  out_valid, bin_out, locked, step_err, wrap_count, wrap_ovf
  );

  modport slave (
    input  in_valid, gray_in,
    output out_valid, bin_out, locked, step_err, wrap_count, wrap_ovf
  );
endinterface

// File: rtl/gray_seq_decoder_gray_to_bin.sv
// Combinational Gray-to-binary decode of a W-bit code.
module gray_to_bin
  import gray_seq_decoder_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  logic [GW-1:0] wide;

  assign wide = gray2bin(GW'(gray));
  assign bin  = wide[W-1:0];
endmodule

// File: rtl/gray_seq_decoder.sv
// Gray stream monitor: decodes each accepted sample, checks it is a hold or +1 step,
// tracks lock with a re-lock run counter, and counts wraps seen while locked.
module gray_seq_decoder
  import gray_seq_decoder_pkg::*;
#(
  parameter int W        = 3,
  parameter int CW       = 4,
  parameter int SYNC_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  gray_seq_decoder_if.slave  bus
);
  localparam int RW = $clog2(SYNC_LEN + 1);

  state_t        state, state_nxt;
  logic [W-1:0]  prev_bin, prev_nxt;
  logic [RW-1:0] run_cnt, run_nxt;
  logic          err_nxt;
  logic [CW-1:0] wrap_count, wrap_nxt;
  logic          wrap_ovf, ovf_nxt;
  logic          out_valid;
  logic          step_err;
  logic [W-1:0]  cur;
  logic          is_hold, is_inc, is_wrap;

  gray_to_bin #(.W(W)) u_dec (
    .gray (bus.gray_in),
    .bin  (cur)
  );

  assign is_hold = (cur == prev_bin);
  assign is_inc  = (cur == prev_bin + W'(1));
  assign is_wrap = is_inc && (prev_bin == {W{1'b1}});

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_bin;
    run_nxt   = run_cnt;
    err_nxt   = 1'b0;
    wrap_nxt  = wrap_count;
    ovf_nxt   = wrap_ovf;
    if (bus.in_valid) begin
      // prev_bin follows every sample, even an illegal one, so re-lock counts from the new position
      prev_nxt = cur;
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RESYNC;
          run_nxt   = '0;
        end
        ST_RESYNC: begin
          if (is_inc) begin
            if (run_cnt == RW'(SYNC_LEN - 1)) begin
              state_nxt = ST_LOCKED;
              run_nxt   = '0;
            end else begin
              run_nxt = run_cnt + RW'(1);
            end
          end else if (!is_hold) begin
            err_nxt = 1'b1;
            run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (is_inc || is_hold) begin
            if (is_wrap) begin
              wrap_nxt = wrap_count + CW'(1);
              if (wrap_count == {CW{1'b1}}) ovf_nxt = 1'b1;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_RESYNC;
            run_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // Output stage: one cycle after the sample edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      prev_bin   <= '0;
      run_cnt    <= '0;
      wrap_count <= '0;
      wrap_ovf   <= 1'b0;
      out_valid  <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_bin   <= prev_nxt;
      run_cnt    <= run_nxt;
      wrap_count <= wrap_nxt;
      wrap_ovf   <= ovf_nxt;
      out_valid  <= bus.in_valid;
      step_err   <= err_nxt;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.bin_out    = prev_bin;
  assign bus.locked     = (state == ST_LOCKED);
  assign bus.step_err   = step_err;
  assign bus.wrap_count = wrap_count;
  assign bus.wrap_ovf   = wrap_ovf;
endmodule

// File: tb/tb_gray_seq_decoder.sv
// Scoreboard bench for gray_seq_decoder (W=3, CW=4, SYNC_LEN=2).
module tb_gray_seq_decoder;
  typedef struct packed {
    logic [2:0] bin;
    logic       locked;
    logic       err;
    logic [3:0] wc;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   nsamp = 0;
  exp_t q[$];

  gray_seq_decoder_if #(.W(3), .CW(4)) bus ();

  gray_seq_decoder #(.W(3), .CW(4), .SYNC_LEN(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output is matched against the oldest expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      exp_t e, a;
      nsamp++;
      a = {bus.bin_out, bus.locked, bus.step_err, bus.wrap_count, bus.wrap_ovf};
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out#%0d: got %0h expected none", nsamp, a);
      end else begin
        e = q.pop_front();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL sample#%0d: got bin=%0d lk=%0b err=%0b wc=%0d ovf=%0b expected bin=%0d lk=%0b err=%0b wc=%0d ovf=%0b",
                   nsamp, a.bin, a.locked, a.err, a.wc, a.ovf, e.bin, e.locked, e.err, e.wc, e.ovf);
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge
  task automatic send(input logic [2:0] g, input logic [2:0] b, input logic lk,
                      input logic err, input logic [3:0] wc, input logic ovf);
    exp_t e;
    e = '{bin: b, locked: lk, err: err, wc: wc, ovf: ovf};
    q.push_back(e);
    bus.in_valid = 1'b1;
    bus.gray_in  = g;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"},  32'(bus.out_valid), 0);
    check({tag, "_bin_out"},    32'(bus.bin_out), 0);
    check({tag, "_locked"},     32'(bus.locked), 0);
    check({tag, "_step_err"},   32'(bus.step_err), 0);
    check({tag, "_wrap_count"}, 32'(bus.wrap_count), 0);
    check({tag, "_wrap_ovf"},   32'(bus.wrap_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] v;
    logic [2:0] g;
    int wraps;
    bus.in_valid = 1'b0;
    bus.gray_in  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    idle();

    // 1: full cycle, locks on third sample, one wrap
    send(3'b000, 3'd0, 0, 0, 4'd0, 0);
    send(3'b001, 3'd1, 0, 0, 4'd0, 0);
    send(3'b011, 3'd2, 1, 0, 4'd0, 0);
    send(3'b010, 3'd3, 1, 0, 4'd0, 0);
    send(3'b110, 3'd4, 1, 0, 4'd0, 0);
    send(3'b111, 3'd5, 1, 0, 4'd0, 0);
    send(3'b101, 3'd6, 1, 0, 4'd0, 0);
    send(3'b100, 3'd7, 1, 0, 4'd0, 0);
    send(3'b000, 3'd0, 1, 0, 4'd1, 0);

    // 2: illegal jump 2->5, then re-lock after two increments
    send(3'b001, 3'd1, 1, 0, 4'd1, 0);
    send(3'b011, 3'd2, 1, 0, 4'd1, 0);
    send(3'b111, 3'd5, 0, 1, 4'd1, 0);
    send(3'b101, 3'd6, 0, 0, 4'd1, 0);
    send(3'b100, 3'd7, 1, 0, 4'd1, 0);

    // 3: holds at 2 with gaps
    send(3'b000, 3'd0, 1, 0, 4'd2, 0);
    send(3'b001, 3'd1, 1, 0, 4'd2, 0);
    send(3'b011, 3'd2, 1, 0, 4'd2, 0);
    for (int i = 0; i < 4; i++) begin
      send(3'b011, 3'd2, 1, 0, 4'd2, 0);
      idle();
      check("gap_out_valid", 32'(bus.out_valid), 0);
      check("gap_step_err",  32'(bus.step_err), 0);
      check("gap_bin_out",   32'(bus.bin_out), 2);
    end
    check("gap_locked", 32'(bus.locked), 1);

    // 4: fresh lock, 17 wraps, overflow stays through an error
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    send(3'b000, 3'd0, 0, 0, 4'd0, 0);
    send(3'b001, 3'd1, 0, 0, 4'd0, 0);
    send(3'b011, 3'd2, 1, 0, 4'd0, 0);
    wraps = 0;
    v = 3'd2;
    for (int c = 0; c < 17 * 8; c++) begin
      v = v + 3'd1;
      g = v ^ (v >> 1);
      if (v == 3'd0) wraps++;
      send(g, v, 1, 0, 4'(wraps), (wraps >= 16));
    end
    check("wrap_count_17", 32'(bus.wrap_count), 1);
    check("wrap_ovf_17",   32'(bus.wrap_ovf), 1);
    send(3'b111, 3'd5, 0, 1, 4'd1, 1);
    send(3'b101, 3'd6, 0, 0, 4'd1, 1);

    // 5: async reset between edges clears outputs at once
    idle();
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    send(3'b110, 3'd4, 0, 0, 4'd0, 0);

    // 6: wrap while resynchronising is not counted but advances the run
    send(3'b100, 3'd7, 0, 1, 4'd0, 0);
    send(3'b000, 3'd0, 0, 0, 4'd0, 0);
    send(3'b001, 3'd1, 1, 0, 4'd0, 0);
    send(3'b011, 3'd2, 1, 0, 4'd0, 0);

    repeat (3) idle();
    check("scoreboard_drained", 32'(q.size()), 0);
    check("samples_seen", 32'(nsamp), 32'(9 + 5 + 7 + 3 + 136 + 2 + 5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
